// File: rtl/dequant_zigzag_writer.sv
`timescale 1ns/1ps
// dequant_zigzag_writer
// Takes quantized coefficients in zig-zag order, dequantizes each one with a
// shift chosen by its diagonal (row + column) and writes it to its raster
// position inside the current 8x8 block of the pre-IDCT SRAM region.
// Blocks run Y, then U, then V. An EOB beat closes a block early: the writer
// generates the remaining zero writes itself.
// Build option: define DEQUANT_SATURATE_EN to clamp dequantized values to the
// signed 16-bit range; without it the low 16 bits are written (wrap-around).
module dequant_zigzag_writer #(
  parameter int PRE_IDCT_BASE = 76800,
  parameter int Y_BLOCK_COLS  = 40,
  parameter int UV_BLOCK_COLS = 20,
  parameter int BLOCK_ROWS    = 30
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enable,
  input  logic        quant_sel,
  input  logic [15:0] coeff_data,
  input  logic        coeff_eob,
  input  logic        coeff_valid,
  output logic        coeff_ready,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        done
);

  // Strides in SRAM words: pixel row within a block, and one full block row.
  localparam int Y_PROW  = Y_BLOCK_COLS * 8;
  localparam int Y_BROW  = Y_PROW * 8;
  localparam int UV_PROW = UV_BLOCK_COLS * 8;
  localparam int UV_BROW = UV_PROW * 8;
  localparam int U_BASE  = PRE_IDCT_BASE + Y_BROW * BLOCK_ROWS;
  localparam int V_BASE  = U_BASE + UV_BROW * BLOCK_ROWS;

  // The Y segment has the widest block row, so it sizes the column counter.
  localparam int COL_W = (Y_BLOCK_COLS > 1) ? $clog2(Y_BLOCK_COLS) : 1;
  localparam int ROW_W = (BLOCK_ROWS > 1) ? $clog2(BLOCK_ROWS) : 1;

  localparam logic [COL_W-1:0] Y_LAST_COL  = COL_W'(Y_BLOCK_COLS - 1);
  localparam logic [COL_W-1:0] UV_LAST_COL = COL_W'(UV_BLOCK_COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(BLOCK_ROWS - 1);

  // Zig-zag index -> raster position (row*8 + col) within an 8x8 block.
  localparam logic [5:0] ZZ_TO_RASTER [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FILL,
    S_BLOCK_END,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SEG_Y,
    SEG_U,
    SEG_V
  } seg_t;

  state_t           state;
  seg_t             segment;
  logic [5:0]       idx;
  logic [COL_W-1:0] block_col;
  logic [ROW_W-1:0] block_row;
  logic             blk_quant;   // quant table latched at block start

  logic [5:0]       raster;
  logic [2:0]       pos_r;
  logic [2:0]       pos_c;
  logic [3:0]       diag;
  logic [2:0]       shift;
  logic [15:0]      dq_value;
  logic [17:0]      wr_addr;
  int               y_addr;
  int               uv_off;
  logic [COL_W-1:0] last_col;
  logic             frame_end;
  logic             accept;

  assign raster = ZZ_TO_RASTER[idx];
  assign pos_r  = raster[5:3];
  assign pos_c  = raster[2:0];
  assign diag   = {1'b0, pos_r} + {1'b0, pos_c};
  assign accept = coeff_valid && coeff_ready;

  assign last_col  = (segment == SEG_Y) ? Y_LAST_COL : UV_LAST_COL;
  assign frame_end = (segment == SEG_V) && (block_row == LAST_ROW) &&
                     (block_col == UV_LAST_COL);

  // Dequantization shift for the current position, from the latched table.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    shift = 3'd0;
    if (!blk_quant) begin
      if (diag == 4'd0)      shift = 3'd3;
      else if (diag == 4'd1) shift = 3'd2;
      else if (diag == 4'd2) shift = 3'd3;
      else if (diag <= 4'd4) shift = 3'd4;
      else if (diag <= 4'd6) shift = 3'd5;
      else                   shift = 3'd6;
    end else begin
      if (diag == 4'd0)      shift = 3'd3;
      else if (diag <= 4'd3) shift = 3'd1;
      else if (diag <= 4'd5) shift = 3'd2;
      else if (diag <= 4'd7) shift = 3'd3;
      else                   shift = 3'd4;
    end
  end

`ifdef DEQUANT_SATURATE_EN
  logic signed [22:0] coeff_ext;
  logic signed [22:0] shifted;

  assign coeff_ext = {{7{coeff_data[15]}}, coeff_data};
  assign shifted   = coeff_ext <<< shift;

  // Clamp the widened product into the signed 16-bit range.
  always_comb begin
    if (shifted > 23'sd32767)       dq_value = 16'h7FFF;
    else if (shifted < -23'sd32768) dq_value = 16'h8000;
    else                            dq_value = shifted[15:0];
  end
`else
  // Only the low 16 bits of the widened product survive, so shifting in a
  // 16-bit context gives the same wrapped result.
  assign dq_value = coeff_data << shift;
`endif

  // SRAM word address of the current position in the current block.
  always_comb begin
    y_addr = PRE_IDCT_BASE + int'(block_row) * Y_BROW + int'(block_col) * 8 +
             int'(pos_r) * Y_PROW + int'(pos_c);
    uv_off = int'(block_row) * UV_BROW + int'(block_col) * 8 +
             int'(pos_r) * UV_PROW + int'(pos_c);
    unique case (segment)
      SEG_Y:   wr_addr = 18'(y_addr);
      SEG_U:   wr_addr = 18'(U_BASE + uv_off);
      default: wr_addr = 18'(V_BASE + uv_off);
    endcase
  end

  // Control FSM with registered SRAM, handshake and done outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state           <= S_IDLE;
      segment         <= SEG_Y;
      idx             <= '0;
      block_col       <= '0;
      block_row       <= '0;
      blk_quant       <= 1'b0;
      coeff_ready     <= 1'b0;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      done            <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values and the defaults below are simply overridden.
      SRAM_we_n <= 1'b1;
      done      <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (Enable) begin
            state       <= S_RUN;
            segment     <= SEG_Y;
            idx         <= '0;
            block_col   <= '0;
            block_row   <= '0;
            blk_quant   <= quant_sel;
            coeff_ready <= 1'b1;
          end
        end

        S_RUN: begin
          if (accept) begin
            if (coeff_eob) begin
              // The marker itself writes nothing; FILL starts at idx.
              state       <= S_FILL;
              coeff_ready <= 1'b0;
            end else begin
              SRAM_we_n       <= 1'b0;
              SRAM_address    <= wr_addr;
              SRAM_write_data <= dq_value;
              idx             <= idx + 6'd1;
              if (idx == 6'd63) begin
                state       <= S_BLOCK_END;
                coeff_ready <= 1'b0;
              end
            end
          end
        end

        S_FILL: begin
          SRAM_we_n       <= 1'b0;
          SRAM_address    <= wr_addr;
          SRAM_write_data <= '0;
          idx             <= idx + 6'd1;
          if (idx == 6'd63) state <= S_BLOCK_END;
        end

        S_BLOCK_END: begin
          idx <= '0;
          if (frame_end) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state       <= S_RUN;
            coeff_ready <= 1'b1;
            blk_quant   <= quant_sel;
            if (block_col == last_col) begin
              block_col <= '0;
              if (block_row == LAST_ROW) begin
                block_row <= '0;
                segment   <= (segment == SEG_Y) ? SEG_U : SEG_V;
              end else begin
                block_row <= block_row + ROW_W'(1);
              end
            end else begin
              block_col <= block_col + COL_W'(1);
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state       <= S_IDLE;
          coeff_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dequant_zigzag_writer.sv
`timescale 1ns/1ps
// Directed bench for dequant_zigzag_writer. A full-size instance checks
// addresses, dequantization and handshake; a reduced-geometry instance runs a
// whole frame (Y, U, V) to check segment sequencing and the done pulse.
module tb_dequant_zigzag_writer;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        Resetn;

  // Full-size instance.
  logic        enable, quant_sel, coeff_eob, coeff_valid;
  logic [15:0] coeff_data;
  logic        coeff_ready, SRAM_we_n, done;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;

  // Reduced instance: 4 Y cols, 2 U/V cols, 2 block rows.
  logic        s_enable, s_quant_sel, s_coeff_eob, s_coeff_valid;
  logic [15:0] s_coeff_data;
  logic        s_coeff_ready, s_we_n, s_done;
  logic [17:0] s_address;
  logic [15:0] s_write_data;

  dequant_zigzag_writer dut (
    .Clock(Clock), .Resetn(Resetn), .Enable(enable), .quant_sel(quant_sel),
    .coeff_data(coeff_data), .coeff_eob(coeff_eob), .coeff_valid(coeff_valid),
    .coeff_ready(coeff_ready), .SRAM_address(SRAM_address),
    .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n), .done(done)
  );

  dequant_zigzag_writer #(
    .PRE_IDCT_BASE(76800), .Y_BLOCK_COLS(4), .UV_BLOCK_COLS(2), .BLOCK_ROWS(2)
  ) dut_small (
    .Clock(Clock), .Resetn(Resetn), .Enable(s_enable), .quant_sel(s_quant_sel),
    .coeff_data(s_coeff_data), .coeff_eob(s_coeff_eob),
    .coeff_valid(s_coeff_valid), .coeff_ready(s_coeff_ready),
    .SRAM_address(s_address), .SRAM_write_data(s_write_data),
    .SRAM_we_n(s_we_n), .done(s_done)
  );

  int checks = 0;
  int failures = 0;

  // Standard JPEG table in its raster -> zig-zag form; inverted at start.
  int raster_to_zz [64] = '{
     0,  1,  5,  6, 14, 15, 27, 28,
     2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,
     9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54,
    20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61,
    35, 36, 48, 49, 57, 58, 62, 63
  };
  int zz_r [64];
  int zz_c [64];

  // Write capture on the falling edge.
  logic [17:0] m_addr [$];
  logic [15:0] m_data [$];
  logic [17:0] s_addr_q [$];
  logic [15:0] s_data_q [$];
  int m_done_cnt = 0;
  int s_done_cnt = 0;
  int s_wr_at_done = -1;

  always @(negedge Clock) begin
    if (Resetn) begin
      if (SRAM_we_n === 1'b0) begin
        m_addr.push_back(SRAM_address);
        m_data.push_back(SRAM_write_data);
      end
      if (s_we_n === 1'b0) begin
        s_addr_q.push_back(s_address);
        s_data_q.push_back(s_write_data);
      end
      if (done === 1'b1) m_done_cnt++;
      if (s_done === 1'b1) begin
        s_done_cnt++;
        s_wr_at_done = s_addr_q.size();
      end
    end
  end

  function automatic int exp_shift(input bit q, input int s);
    if (!q) begin
      if (s == 0) return 3;
      if (s == 1) return 2;
      if (s == 2) return 3;
      if (s <= 4) return 4;
      if (s <= 6) return 5;
      return 6;
    end
    if (s == 0) return 3;
    if (s <= 3) return 1;
    if (s <= 5) return 2;
    if (s <= 7) return 3;
    return 4;
  endfunction

  function automatic logic [15:0] exp_data(input bit q, input int val, input int k);
    int v;
    v = val << exp_shift(q, zz_r[k] + zz_c[k]);
    return v[15:0];
  endfunction

  function automatic int exp_addr(input int seg_base, input int cols, input int row,
                                  input int col, input int k);
    int prow;
    prow = cols * 8;
    return seg_base + row * prow * 8 + col * 8 + zz_r[k] * prow + zz_c[k];
  endfunction

  // Drive point: 2 ns after each rising edge.
  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic send(input logic [15:0] d, input logic e);
    coeff_valid = 1'b1;
    coeff_data  = d;
    coeff_eob   = e;
    tick();
  endtask

  task automatic idle();
    coeff_valid = 1'b0;
    coeff_eob   = 1'b0;
    coeff_data  = 16'h0000;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (coeff_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (coeff_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL %s_timeout: coeff_ready got %b want 1", tag, coeff_ready);
    end
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    repeat (3) tick();
    checks++; if (SRAM_we_n !== 1'b1) begin failures++; $display("FAIL reset_we_n: got %b want 1", SRAM_we_n); end
    checks++; if (SRAM_address !== 18'd0) begin failures++; $display("FAIL reset_addr: got %0d want 0", SRAM_address); end
    checks++; if (SRAM_write_data !== 16'd0) begin failures++; $display("FAIL reset_data: got %h want 0000", SRAM_write_data); end
    checks++; if (coeff_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", coeff_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    Resetn = 1'b1;
    repeat (3) tick();
    checks++; if (coeff_ready !== 1'b0) begin failures++; $display("FAIL idle_ready: got %b want 0", coeff_ready); end
  endtask

  // Block (0,0), Q0: two beats then EOB, 62 fill writes, ready low 63 cycles.
  task automatic test_eob_block();
    int low = 0;
    quant_sel = 1'b0;
    m_addr.delete(); m_data.delete();
    pulse_enable();
    wait_ready("eob_start");
    send(16'd5, 1'b0);
    send(16'hFFFD, 1'b0);
    send(16'h0000, 1'b1);
    idle();
    quant_sel = 1'b1;   // sampled when the next block starts
    while (coeff_ready === 1'b0 && low < 200) begin
      low++;
      tick();
    end
    tick();
    checks++; if (low != 63) begin failures++; $display("FAIL eob_ready_low: got %0d want 63", low); end
    checks++; if (m_addr.size() != 64) begin failures++; $display("FAIL eob_writes: got %0d want 64", m_addr.size()); end
    if (m_addr.size() == 64) begin
      checks++; if (m_addr[0] !== 18'd76800 || m_data[0] !== 16'd40) begin failures++; $display("FAIL eob_w0: got %0d/%h want 76800/0028", m_addr[0], m_data[0]); end
      checks++; if (m_addr[1] !== 18'd76801 || m_data[1] !== 16'hFFF4) begin failures++; $display("FAIL eob_w1: got %0d/%h want 76801/fff4", m_addr[1], m_data[1]); end
      checks++; if (m_addr[63] !== 18'd79047) begin failures++; $display("FAIL eob_w63: got %0d want 79047", m_addr[63]); end
      for (int k = 2; k < 64; k++) begin
        checks++;
        if (m_addr[k] !== 18'(exp_addr(76800, 40, 0, 0, k)) || m_data[k] !== 16'd0) begin
          failures++;
          $display("FAIL eob_fill_%0d: got %0d/%h want %0d/0000", k, m_addr[k], m_data[k], exp_addr(76800, 40, 0, 0, k));
        end
      end
    end
  endtask

  // Block (0,1), Q1: 64 ones, closes without EOB; quant_sel flips mid-block.
  task automatic test_full_block_q1();
    m_addr.delete(); m_data.delete();
    wait_ready("full_start");
    for (int k = 0; k < 64; k++) begin
      if (k == 10) quant_sel = 1'b0;
      send(16'd1, 1'b0);
    end
    idle();
    repeat (2) tick();
    checks++; if (m_addr.size() != 64) begin failures++; $display("FAIL full_writes: got %0d want 64", m_addr.size()); end
    if (m_addr.size() == 64) begin
      checks++; if (m_addr[0] !== 18'd76808 || m_data[0] !== 16'd8) begin failures++; $display("FAIL full_w0: got %0d/%0d want 76808/8", m_addr[0], m_data[0]); end
      checks++; if (m_addr[3] !== 18'd77448 || m_data[3] !== 16'd2) begin failures++; $display("FAIL full_w3: got %0d/%0d want 77448/2", m_addr[3], m_data[3]); end
      checks++; if (m_addr[63] !== 18'd79055 || m_data[63] !== 16'd16) begin failures++; $display("FAIL full_w63: got %0d/%0d want 79055/16", m_addr[63], m_data[63]); end
      for (int k = 0; k < 64; k++) begin
        checks++;
        if (m_addr[k] !== 18'(exp_addr(76800, 40, 0, 1, k)) || m_data[k] !== exp_data(1'b1, 1, k)) begin
          failures++;
          $display("FAIL full_%0d: got %0d/%0d want %0d/%0d", k, m_addr[k], m_data[k], exp_addr(76800, 40, 0, 1, k), exp_data(1'b1, 1, k));
        end
      end
    end
  endtask

  // Block (0,2), Q0: valid 1,0,1 gives two writes separated by one idle cycle.
  task automatic test_valid_toggle();
    logic [3:0] we;
    m_addr.delete(); m_data.delete();
    wait_ready("toggle_start");
    send(16'd3, 1'b0);
    we[0] = SRAM_we_n;
    idle();
    tick();
    we[1] = SRAM_we_n;
    send(16'hFFFF, 1'b0);
    we[2] = SRAM_we_n;
    idle();
    tick();
    we[3] = SRAM_we_n;
    checks++; if (we !== 4'b1010) begin failures++; $display("FAIL toggle_we_n: got %b want 1010 (bit0 first)", we); end
    checks++; if (m_addr.size() != 2) begin failures++; $display("FAIL toggle_writes: got %0d want 2", m_addr.size()); end
    if (m_addr.size() == 2) begin
      checks++; if (m_addr[0] !== 18'd76816 || m_data[0] !== 16'd24) begin failures++; $display("FAIL toggle_w0: got %0d/%0d want 76816/24", m_addr[0], m_data[0]); end
      checks++; if (m_addr[1] !== 18'd76817 || m_data[1] !== 16'hFFFC) begin failures++; $display("FAIL toggle_w1: got %0d/%h want 76817/fffc", m_addr[1], m_data[1]); end
    end
    send(16'h0000, 1'b1);
    idle();
    tick();
    wait_ready("toggle_end");
  endtask

  // Block (0,3), Q0: 0x4000 at idx0 overflows after the shift by 3.
  task automatic test_saturate();
    logic [15:0] want;
`ifdef DEQUANT_SATURATE_EN
    want = 16'h7FFF;
`else
    want = 16'h0000;
`endif
    m_addr.delete(); m_data.delete();
    send(16'h4000, 1'b0);
    send(16'h0000, 1'b1);
    idle();
    tick();
    checks++; if (m_addr.size() < 1 || m_addr[0] !== 18'd76824 || m_data[0] !== want) begin
      failures++;
      $display("FAIL saturate_w0: got %0d/%h want 76824/%h", (m_addr.size() > 0) ? m_addr[0] : 18'd0, (m_data.size() > 0) ? m_data[0] : 16'd0, want);
    end
    wait_ready("saturate_end");
  endtask

  // Block (0,4) EOB with Enable pulsed during FILL; block (0,5) must follow.
  task automatic test_enable_busy();
    send(16'h0000, 1'b1);
    idle();
    repeat (3) tick();
    pulse_enable();
    wait_ready("busy_end");
    m_addr.delete(); m_data.delete();
    send(16'd1, 1'b0);
    idle();
    tick();
    checks++; if (m_addr.size() != 1 || m_addr[0] !== 18'd76840 || m_data[0] !== 16'd8) begin
      failures++;
      $display("FAIL busy_next_block: got n=%0d addr=%0d want n=1 addr=76840 data=8", m_addr.size(), (m_addr.size() > 0) ? m_addr[0] : 18'd0);
    end
    checks++; if (m_done_cnt != 0) begin failures++; $display("FAIL busy_done: got %0d want 0", m_done_cnt); end
  endtask

  // Whole frame on the reduced instance: 8 Y, 4 U, 4 V blocks, EOB only.
  task automatic test_frame();
    int exp_q [$];
    int n;
    int bad = 0;
    int first_bad = -1;
    int cols, base;
    s_addr_q.delete(); s_data_q.delete();
    s_enable = 1'b1;
    tick();
    s_enable = 1'b0;
    for (int seg = 0; seg < 3; seg++) begin
      cols = (seg == 0) ? 4 : 2;
      base = (seg == 0) ? 76800 : (seg == 1) ? 77312 : 77568;
      for (int row = 0; row < 2; row++) begin
        for (int col = 0; col < cols; col++) begin
          n = 0;
          while (s_coeff_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
          end
          if (s_coeff_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL frame_ready_timeout: seg %0d row %0d col %0d", seg, row, col);
          end
          s_coeff_valid = 1'b1;
          s_coeff_eob   = 1'b1;
          tick();
          s_coeff_valid = 1'b0;
          s_coeff_eob   = 1'b0;
          for (int k = 0; k < 64; k++) exp_q.push_back(exp_addr(base, cols, row, col, k));
        end
      end
    end
    n = 0;
    while (s_done_cnt == 0 && n < 300) begin
      tick();
      n++;
    end
    repeat (5) tick();
    checks++; if (s_done_cnt != 1) begin failures++; $display("FAIL frame_done_pulses: got %0d want 1", s_done_cnt); end
    checks++; if (s_wr_at_done != 1024) begin failures++; $display("FAIL frame_done_after_last: writes at done %0d want 1024", s_wr_at_done); end
    checks++; if (s_addr_q.size() != 1024) begin failures++; $display("FAIL frame_writes: got %0d want 1024", s_addr_q.size()); end
    checks++; if (s_coeff_ready !== 1'b0) begin failures++; $display("FAIL frame_idle_ready: got %b want 0", s_coeff_ready); end
    if (s_addr_q.size() == 1024) begin
      checks++; if (s_addr_q[512] !== 18'd77312) begin failures++; $display("FAIL frame_first_u: got %0d want 77312", s_addr_q[512]); end
      checks++; if (s_addr_q[768] !== 18'd77568) begin failures++; $display("FAIL frame_first_v: got %0d want 77568", s_addr_q[768]); end
      checks++; if (s_addr_q[1023] !== 18'd77823) begin failures++; $display("FAIL frame_last: got %0d want 77823", s_addr_q[1023]); end
      for (int k = 0; k < 1024; k++) begin
        if (s_addr_q[k] !== 18'(exp_q[k]) || s_data_q[k] !== 16'd0) begin
          bad++;
          if (first_bad < 0) first_bad = k;
        end
      end
      checks++; if (bad != 0) begin
        failures++;
        $display("FAIL frame_addr_seq: %0d bad, first at %0d got %0d want %0d", bad, first_bad, s_addr_q[first_bad], exp_q[first_bad]);
      end
    end
  endtask

  // Main instance: reset asserted mid-FILL, then restart from block (0,0).
  task automatic test_reset_mid_fill();
    send(16'h0000, 1'b1);
    idle();
    repeat (3) tick();
    checks++; if (SRAM_we_n !== 1'b0) begin failures++; $display("FAIL midfill_writing: we_n got %b want 0", SRAM_we_n); end
    #1 Resetn = 1'b0;
    #1;
    checks++; if (SRAM_we_n !== 1'b1) begin failures++; $display("FAIL midfill_async_we_n: got %b want 1", SRAM_we_n); end
    checks++; if (coeff_ready !== 1'b0) begin failures++; $display("FAIL midfill_async_ready: got %b want 0", coeff_ready); end
    repeat (2) tick();
    Resetn = 1'b1;
    m_addr.delete(); m_data.delete();
    repeat (4) tick();
    checks++; if (coeff_ready !== 1'b0 || m_addr.size() != 0) begin
      failures++;
      $display("FAIL midfill_stays_idle: ready %b writes %0d want 0/0", coeff_ready, m_addr.size());
    end
    pulse_enable();
    wait_ready("restart");
    send(16'd2, 1'b0);
    idle();
    tick();
    checks++; if (m_addr.size() != 1 || m_addr[0] !== 18'd76800 || m_data[0] !== 16'd16) begin
      failures++;
      $display("FAIL restart_w0: got n=%0d addr=%0d want n=1 addr=76800 data=16", m_addr.size(), (m_addr.size() > 0) ? m_addr[0] : 18'd0);
    end
  endtask

  initial begin
    for (int p = 0; p < 64; p++) begin
      zz_r[raster_to_zz[p]] = p / 8;
      zz_c[raster_to_zz[p]] = p % 8;
    end
    Resetn = 1'b0;
    enable = 1'b0; quant_sel = 1'b0; coeff_eob = 1'b0; coeff_valid = 1'b0; coeff_data = 16'h0000;
    s_enable = 1'b0; s_quant_sel = 1'b0; s_coeff_eob = 1'b0; s_coeff_valid = 1'b0; s_coeff_data = 16'h0000;

    test_reset();
    test_eob_block();
    test_full_block_q1();
    test_valid_toggle();
    test_saturate();
    test_enable_busy();
    test_frame();
    test_reset_mid_fill();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dequant_zigzag_writer.md
Name: dequant_zigzag_writer

Overview:
- Upstream neighbour of the IDCT stage: takes decoded quantized coefficients in zig-zag order from the lossless decoder and dequantizes them.
- Writes the results to SRAM in the pre-IDCT region, raster order within each 8x8 block, in the block layout the IDCT stage reads.
- One 16-bit SRAM write per accepted coefficient; End-Of-Block (EOB) markers trigger self-generated zero fill.

Parameters:
- PRE_IDCT_BASE, 76800: SRAM word address of the Y pre-IDCT segment.
- Y_BLOCK_COLS, 40: Y blocks per block row (row stride 320 words).
- UV_BLOCK_COLS, 20: U/V blocks per block row (row stride 160 words).
- BLOCK_ROWS, 30: block rows per segment.

Ports:
- Clock  in  1  system clock
- Resetn  in  1  asynchronous active-low reset
- Enable  in  1  start pulse; honoured only in IDLE
- quant_sel  in  1  0=Q0, 1=Q1; sampled at each block start
- coeff_data  in  16  signed quantized coefficient
- coeff_eob  in  1  marker beat: rest of block is zero; coeff_data ignored
- coeff_valid  in  1  beat valid
- coeff_ready  out  1  beat accepted when valid && ready at rising edge
- SRAM_address  out  18  write address
- SRAM_write_data  out  16  dequantized value
- SRAM_we_n  out  1  active-low write enable
- done  out  1  one-cycle pulse after the last write of the frame

Behaviour:
- Clock and reset: single clock Clock; Resetn asynchronous, active-low.
- Reset values: SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, coeff_ready=0, done=0, state=IDLE, all counters 0.
- States:
  - IDLE: Enable -> RUN; block counters cleared, segment=Y.
  - RUN: coeff_ready=1.
    - Accepted non-EOB beat: write, idx++.
    - idx 63 accepted -> BLOCK_END.
    - Accepted EOB beat -> FILL; the EOB beat itself produces no write.
  - FILL: coeff_ready=0; one zero write per cycle for positions idx..63, then BLOCK_END.
  - BLOCK_END (1 cycle, ready=0): advance block_col, wrapping at the segment's column count into block_row; block_row wraps at BLOCK_ROWS into the next segment (Y->U->V). After block 2400 (V, row 29, col 19) -> DONE, else RUN.
  - DONE: done=1 for one cycle -> IDLE.
- Position mapping: idx 0..63 maps through the standard JPEG zig-zag table to (r,c).
  - Examples: idx1=(0,1), idx2=(1,0), idx3=(2,0), idx63=(7,7).
- Address calculation:
  - Y: PRE_IDCT_BASE + block_row*2560 + block_col*8 + r*320 + c.
  - U: base+76800 + block_row*1280 + block_col*8 + r*160 + c.
  - V: base+115200, same strides as U.
  - Last word written is 230399.
- Dequantization: value = coeff <<< shift(s), s=r+c.
  - Q0 shifts: s0:3, s1:2, s2:3, s3-4:4, s5-6:5, s>=7:6.
  - Q1 shifts: s0:3, s1-3:1, s4-5:2, s6-7:3, s>=8:4.
  - Shifting is done in 23-bit signed arithmetic, then reduced to 16 bits (see optional feature).
- Latency: a beat accepted at edge k drives SRAM_we_n=0 with its address/data during cycle k+1. All SRAM outputs are registered; SRAM_we_n is low exactly one cycle per write.
- Back-to-back beats give one write per cycle. Valid low in RUN gives no write and SRAM_we_n=1.
- Boundary cases:
  - EOB at idx 0 -> 64 zero writes.
  - EOB never coincides with idx 64; the block closes automatically after idx 63.
  - Enable while busy is ignored.
  - quant_sel changes mid-block take effect at the next block.
- Reset mid-operation returns to IDLE immediately with SRAM_we_n=1. A partially written block is not resumed.

Optional Feature:
- Macro: DEQUANT_SATURATE_EN.
- Defined: a shifted value above 32767 becomes 32767; below -32768 becomes -32768.
- Undefined: the low 16 bits are written (wrap-around). Saves comparators.

Test Plan:
- Reset, Enable, Q0, first Y block beats idx0=5, idx1=-3, then EOB -> writes 76800=40, 76801=-12, then zero writes to 76802..79047 in raster-block addresses (62 writes). coeff_ready low for 63 cycles: 62 FILL plus 1 BLOCK_END.
- Full block of 64 ones, Q1, block_col=1 -> idx63 written at 76800+8+7*320+7=79055 with value 16; no EOB required.
- valid toggling 1,0,1 -> exactly two writes, SRAM_we_n pulses separated by one high cycle.
- Stream 2400 blocks each EOB-only -> last write at 230399, done pulses once. First U write lands at 153600 and first V write at 192000.
- coeff 0x4000, idx0, Q0 -> with DEQUANT_SATURATE_EN writes 0x7FFF; without it writes 0x0000.
- Resetn low mid-FILL -> SRAM_we_n=1 and coeff_ready=0 asynchronously; after release the block stays IDLE until Enable.
